// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
// Holds the FSM state encoding and the helper used to size requester ids.
package mult_arb_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOAD_A = 4'd1,
      LOAD_B = 4'd2,
      WAIT   = 4'd3,
      RESP   = 4'd4
   } state_t;

   localparam int DEF_N       = 4;
   localparam int DEF_W       = 8;
   localparam int DEF_TIMEOUT = 64;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rotates the request vector by ptr, priority-encodes, then adds ptr back mod N.
module rr_pick
   import mult_arb_pkg::*;
#(
   parameter  int N  = DEF_N,
   localparam int IW = id_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] winner
);

   localparam int DW = $clog2(2 * N);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  idx;
   logic [IW:0]    sum_raw;

   assign req_dbl = {req, req};

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rot
         assign rot[gi] = req_dbl[DW'(ptr) + DW'(gi)];
      end
   endgenerate

   // Lowest set bit of the rotated vector is the nearest requester after ptr.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) idx = IW'(i);
      end
   end

   assign sum_raw = {1'b0, idx} + {1'b0, ptr};
   assign winner  = (sum_raw >= (IW+1)'(N)) ? IW'(sum_raw - (IW+1)'(N)) : sum_raw[IW-1:0];
   assign any     = |req;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential shift-and-add multiplier among N requesters.
// Round-robin grant, A/B operand sequencing, done/timeout wait, tagged response.
module mult_share_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int W       = DEF_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N-1:0]            req,
   input  logic [N*W-1:0]          opa,
   input  logic [N*W-1:0]          opb,
   output logic                    rsp_valid,
   output logic [id_width(N)-1:0]  rsp_id,
   output logic [2*W-1:0]          rsp_product,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    mul_start,
   output logic [W-1:0]            mul_data,
   input  logic                    mul_done,
   input  logic [W-1:0]            mul_acc,
   input  logic [W-1:0]            mul_a
);

   localparam int IW = id_width(N);
   localparam int TW = $clog2(TIMEOUT);

   state_t          state_reg, state_next;
   logic [IW-1:0]   ptr_reg, ptr_next;
   logic [IW-1:0]   id_reg, id_next;
   logic [W-1:0]    b_reg, b_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic            rsp_valid_reg, rsp_valid_next;
   logic [IW-1:0]   rsp_id_reg, rsp_id_next;
   logic [2*W-1:0]  rsp_product_reg, rsp_product_next;
   logic            rsp_err_reg, rsp_err_next;
   logic            busy_reg, busy_next;
   logic            mul_start_reg, mul_start_next;
   logic [W-1:0]    mul_data_reg, mul_data_next;

   logic            pick_any;
   logic [IW-1:0]   pick_id;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (ptr_reg),
      .any    (pick_any),
      .winner (pick_id)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg       <= IDLE;
         ptr_reg         <= '0;
         id_reg          <= '0;
         b_reg           <= '0;
         timer_reg       <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_id_reg      <= '0;
         rsp_product_reg <= '0;
         rsp_err_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         mul_start_reg   <= 1'b0;
         mul_data_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         ptr_reg         <= ptr_next;
         id_reg          <= id_next;
         b_reg           <= b_next;
         timer_reg       <= timer_next;
         rsp_valid_reg   <= rsp_valid_next;
         rsp_id_reg      <= rsp_id_next;
         rsp_product_reg <= rsp_product_next;
         rsp_err_reg     <= rsp_err_next;
         busy_reg        <= busy_next;
         mul_start_reg   <= mul_start_next;
         mul_data_reg    <= mul_data_next;
      end
   end

   // Outputs are registered, so each *_next is the value seen during state_next.
   always_comb begin
      state_next       = state_reg;
      ptr_next         = ptr_reg;
      id_next          = id_reg;
      b_next           = b_reg;
      timer_next       = timer_reg;
      rsp_valid_next   = 1'b0;
      rsp_id_next      = rsp_id_reg;
      rsp_product_next = rsp_product_reg;
      rsp_err_next     = rsp_err_reg;
      mul_start_next   = 1'b0;
      mul_data_next    = mul_data_reg;

      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               id_next        = pick_id;
               b_next         = opb[int'(pick_id) * W +: W];
               mul_data_next  = opa[int'(pick_id) * W +: W];
               mul_start_next = 1'b1;
               state_next     = LOAD_A;
            end
         end
         LOAD_A: begin
            mul_data_next = b_reg;
            timer_next    = '0;
            state_next    = LOAD_B;
         end
         LOAD_B: begin
            state_next = WAIT;
         end
         WAIT: begin
            timer_next = timer_reg + 1'b1;
            // A done arriving on the last allowed cycle still counts as success.
            if (mul_done) begin
               rsp_valid_next   = 1'b1;
               rsp_id_next      = id_reg;
               rsp_product_next = {mul_acc, mul_a};
               rsp_err_next     = 1'b0;
               state_next       = RESP;
            end else if (timer_reg == TW'(TIMEOUT - 1)) begin
               rsp_valid_next   = 1'b1;
               rsp_id_next      = id_reg;
               rsp_product_next = '0;
               rsp_err_next     = 1'b1;
               state_next       = RESP;
            end
         end
         RESP: begin
            ptr_next   = (id_reg == IW'(N - 1)) ? '0 : id_reg + 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   assign rsp_valid   = rsp_valid_reg;
   assign rsp_id      = rsp_id_reg;
   assign rsp_product = rsp_product_reg;
   assign rsp_err     = rsp_err_reg;
   assign busy        = busy_reg;
   assign mul_start   = mul_start_reg;
   assign mul_data    = mul_data_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural shift-add multiplier model.
// Expected products, ids and latencies are hand-computed constants.
module tb_mult_share_arbiter;

   localparam int N       = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 64;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] opa = '0;
   logic [N*W-1:0] opb = '0;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [2*W-1:0] rsp_product;
   logic           rsp_err;
   logic           busy;
   logic           mul_start;
   logic [W-1:0]   mul_data;
   logic           mul_done;
   logic [W-1:0]   mul_acc;
   logic [W-1:0]   mul_a;

   int n_checks = 0;
   int n_fail   = 0;

   // Multiplier model: A on the start cycle, B the next, done model_lat cycles later.
   int          model_lat  = 9;
   bit          never_done = 1'b0;
   logic        force_done = 1'b0;
   logic        model_done;
   logic [W-1:0] m_a, m_b;
   int          m_phase, m_cnt;

   assign mul_done = model_done | force_done;

   always #5 i_clk = ~i_clk;

   mult_share_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .req         (req),
      .opa         (opa),
      .opb         (opb),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_data    (mul_data),
      .mul_done    (mul_done),
      .mul_acc     (mul_acc),
      .mul_a       (mul_a)
   );

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_phase    <= 0;
         m_cnt      <= 0;
         model_done <= 1'b0;
         m_a        <= '0;
         m_b        <= '0;
         mul_acc    <= '0;
         mul_a      <= '0;
      end else begin
         model_done <= 1'b0;
         if (mul_start) begin
            m_a     <= mul_data;
            m_phase <= 1;
         end else if (m_phase == 1) begin
            m_b     <= mul_data;
            m_cnt   <= 1;
            m_phase <= 2;
         end else if (m_phase == 2) begin
            if (m_cnt == model_lat) begin
               {mul_acc, mul_a} <= 16'(m_a) * 16'(m_b);
               model_done       <= !never_done;
               m_phase          <= 0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      opa[id*W +: W] = a;
      opb[id*W +: W] = b;
   endtask

   // Counts negedges from 'start'; returns the cycle index at which rsp_valid is seen.
   task automatic wait_rsp(input int start, output int cycles);
      cycles = -1;
      for (int i = start + 1; i <= start + 200; i++) begin
         @(negedge i_clk);
         if (rsp_valid) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic expect_rsp(input int start, input int exp_id, input logic [15:0] exp_p,
                             input logic exp_err, input int exp_cyc);
      int cyc;
      wait_rsp(start, cyc);
      check("latency", cyc, exp_cyc);
      check("rsp_id", rsp_id, exp_id);
      check("rsp_product", rsp_product, exp_p);
      check("rsp_err", rsp_err, exp_err);
      $display("txn id=%0d product=0x%04h err=%0b latency=%0d", rsp_id, rsp_product, rsp_err, cyc);
   endtask

   task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [15:0] exp_p, input logic exp_err, input int exp_cyc);
      set_ops(id, a, b);
      req     = '0;
      req[id] = 1'b1;
      expect_rsp(0, id, exp_p, exp_err, exp_cyc);
      req = '0;
      @(negedge i_clk);
      check("pulse_end", rsp_valid, 0);
      check("held_product", rsp_product, exp_p);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [15:0] prod_tbl [N];
   int          seq_tbl  [5];

   initial begin
      prod_tbl = '{16'd6, 16'd12, 16'd20, 16'd30};
      seq_tbl  = '{0, 1, 2, 3, 0};

      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_mul_data", mul_data, 0);
      check("rst_rsp_product", rsp_product, 0);
      check("rst_rsp_id", rsp_id, 0);
      @(negedge i_clk);

      // Single requester with cycle-level bus checks: 13 * 11 = 143.
      set_ops(0, 8'd13, 8'd11);
      req = 4'b0001;
      @(negedge i_clk);
      check("c1_mul_start", mul_start, 1);
      check("c1_mul_data", mul_data, 13);
      check("c1_busy", busy, 1);
      @(negedge i_clk);
      check("c2_mul_start", mul_start, 0);
      check("c2_mul_data", mul_data, 11);
      expect_rsp(2, 0, 16'h008F, 1'b0, 13);
      req = '0;
      @(negedge i_clk);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_held_product", rsp_product, 16'h008F);

      // Max operands, then id3 alone to bring the pointer back to 0.
      single(2, 8'd255, 8'd255, 16'hFE01, 1'b0, 13);
      single(3, 8'd16, 8'd16, 16'h0100, 1'b0, 13);

      // Simultaneous req 1010 from pointer 0: id1 then id3.
      set_ops(1, 8'd3, 8'd4);
      set_ops(3, 8'd5, 8'd6);
      req = 4'b1010;
      expect_rsp(0, 1, 16'd12, 1'b0, 13);
      req[1] = 1'b0;
      expect_rsp(-1, 3, 16'd30, 1'b0, 13);
      req = '0;
      @(negedge i_clk);

      // All four held: grants rotate 0,1,2,3,0.
      for (int i = 0; i < N; i++) set_ops(i, W'(i + 2), W'(i + 3));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expect_rsp((k == 0) ? 0 : -1, seq_tbl[k], prod_tbl[seq_tbl[k]], 1'b0, 13);
      end
      req = '0;
      @(negedge i_clk);

      // Timeout: no done at all, response TIMEOUT cycles after WAIT entry.
      never_done = 1'b1;
      single(1, 8'd3, 8'd5, 16'h0000, 1'b1, 3 + TIMEOUT);
      never_done = 1'b0;
      single(2, 8'd12, 8'd10, 16'h0078, 1'b0, 13);

      // Spurious done during LOAD_A is ignored.
      set_ops(3, 8'd9, 8'd9);
      req = 4'b1000;
      @(negedge i_clk);
      check("spur_mul_start", mul_start, 1);
      force_done = 1'b1;
      @(negedge i_clk);
      force_done = 1'b0;
      expect_rsp(2, 3, 16'h0051, 1'b0, 13);
      req = '0;
      @(negedge i_clk);

      // Done on the final timeout cycle wins over the timeout.
      model_lat = TIMEOUT - 1;
      single(0, 8'd200, 8'd3, 16'h0258, 1'b0, 3 + TIMEOUT);
      model_lat = 9;

      // Asynchronous reset mid-WAIT, then the still-pending request is served.
      set_ops(1, 8'd7, 8'd6);
      req = 4'b0010;
      repeat (5) @(negedge i_clk);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_mul_data", mul_data, 6);
      #2 i_rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_mul_start", mul_start, 0);
      check("arst_mul_data", mul_data, 0);
      check("arst_rsp_valid", rsp_valid, 0);
      check("arst_rsp_product", rsp_product, 0);
      repeat (2) @(negedge i_clk);
      check("in_rst_rsp_valid", rsp_valid, 0);
      i_rst = 1'b0;
      expect_rsp(0, 1, 16'h002A, 1'b0, 13);
      req = '0;
      @(negedge i_clk);
      check("final_rsp_valid", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
